// File: rtl/run_monitor_pkg.sv
// run_monitor_pkg: shared types and widths for the run monitor.
//   PC_W    - width of the CPU PC_plus_1 bus
//   CNT_W   - width of the run cycle counter
//   state_t - run monitor FSM states (TIMEOUT exists only when
//             RUN_MONITOR_WATCHDOG_EN is defined)
package run_monitor_pkg;

  localparam int PC_W  = 16;
  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_HALTED
`ifdef RUN_MONITOR_WATCHDOG_EN
    , S_TIMEOUT
`endif
  } state_t;

endpackage

// File: rtl/run_monitor_cnt.sv
// run_monitor_cnt: clear/enable saturating cycle counter.
//   clk, rst - clock, async active-high reset
//   clr      - synchronous clear (wins over en)
//   en       - count enable; holds at all-ones once saturated
//   count    - current count
module run_monitor_cnt
  import run_monitor_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     count <= '0;
    else if (clr)                count <= '0;
    else if (en && count != '1)  count <= count + 1'b1;
  end

endmodule

// File: rtl/run_monitor.sv
// run_monitor: drives the CPU reset for a run, then watches for halt
// (and, optionally, a watchdog limit) while counting run cycles.
//   Macro RUN_MONITOR_WATCHDOG_EN enables the TIMEOUT state and the
//   CYCLES_LIMIT compare; without it timeout is tied low.
//   clk, rst   - clock, async active-high reset
//   start      - one-cycle run request (honoured in IDLE/HALTED/TIMEOUT)
//   hlt, pc    - CPU halt flag and PC_plus_1, only looked at in RUN
//   cpu_rst_n  - reset to the CPU, low for RST_HOLD cycles per run
//   running    - CPU out of reset and still going
//   done       - last run ended on a halt
//   timeout    - last run ended on the watchdog
//   cycles     - RUN cycles in the current/last run
//   halt_pc    - pc captured on the halt edge
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int CYCLES_LIMIT = 100000,
  parameter int RST_HOLD     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hlt,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_rst_n,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles,
  output logic [PC_W-1:0]  halt_pc
);

  if (RST_HOLD < 1 || RST_HOLD > 15) begin : g_bad_hold
    $error("run_monitor: RST_HOLD out of range 1..15");
  end
  if (CYCLES_LIMIT < 1) begin : g_bad_limit
    $error("run_monitor: CYCLES_LIMIT must be positive");
  end

  state_t     state;
  logic [3:0] hold_cnt;
  logic       hlt_q;
  logic       can_start;
  logic       go;
  logic       halt_edge;

  // hlt is sampled every cycle so a level already high on RUN entry
  // looks like "no change" rather than a fresh rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hlt_q <= 1'b0;
    else     hlt_q <= hlt;
  end

  assign halt_edge = hlt & ~hlt_q;

  always_comb begin
    can_start = 1'b0;
    case (state)
      S_IDLE, S_HALTED: can_start = 1'b1;
`ifdef RUN_MONITOR_WATCHDOG_EN
      S_TIMEOUT:        can_start = 1'b1;
`endif
      default:          can_start = 1'b0;
    endcase
  end

  assign go = start & can_start;

  // Counts every RUN cycle, including the one that ends the run.
  run_monitor_cnt u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (go),
    .en    (state == S_RUN),
    .count (cycles)
  );

`ifdef RUN_MONITOR_WATCHDOG_EN
  localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(CYCLES_LIMIT - 1);
  logic limit_hit;
  // The counter is about to step onto CYCLES_LIMIT on this edge.
  assign limit_hit = (cycles == LIM_M1);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      hold_cnt  <= '0;
      cpu_rst_n <= 1'b0;
      running   <= 1'b0;
      done      <= 1'b0;
      halt_pc   <= '0;
`ifdef RUN_MONITOR_WATCHDOG_EN
      timeout   <= 1'b0;
`endif
    end else if (go) begin
      state     <= S_HOLD;
      hold_cnt  <= 4'(RST_HOLD);
      cpu_rst_n <= 1'b0;
      running   <= 1'b0;
      done      <= 1'b0;
`ifdef RUN_MONITOR_WATCHDOG_EN
      timeout   <= 1'b0;
`endif
    end else begin
      case (state)
        S_HOLD: begin
          // Leaving on the count==1 edge gives exactly RST_HOLD low cycles.
          if (hold_cnt <= 4'd1) begin
            state     <= S_RUN;
            cpu_rst_n <= 1'b1;
            running   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        S_RUN: begin
          // Halt takes priority over the watchdog on a shared cycle.
          if (halt_edge) begin
            state   <= S_HALTED;
            halt_pc <= pc;
            done    <= 1'b1;
            running <= 1'b0;
          end
`ifdef RUN_MONITOR_WATCHDOG_EN
          else if (limit_hit) begin
            state   <= S_TIMEOUT;
            timeout <= 1'b1;
            running <= 1'b0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
